// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the branch predictor (BTB + 2-bit direction counters).
package bp_pkg;

  // Controller states: S_CLEAR sweeps the table invalid, S_RUN serves lookups/updates.
  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } bp_state_e;

  // Direction counter encodings for the 2-bit case.
  localparam logic [1:0] CTR_SNT = 2'd0;  // strongly not-taken
  localparam logic [1:0] CTR_WNT = 2'd1;  // weakly not-taken
  localparam logic [1:0] CTR_WT  = 2'd2;  // weakly taken
  localparam logic [1:0] CTR_ST  = 2'd3;  // strongly taken

endpackage

// File: rtl/branch_predictor_if.sv
// Lookup and training bundle between the pipeline (master) and the predictor (slave).
// Handshake: lk_pc is presented every cycle and lk_* answer combinationally in the same cycle.
// upd_valid qualifies upd_* for exactly the cycle it is high; there is no ready, and the
// predictor silently drops an update while it is sweeping or when flush_all is raised.
interface branch_predictor_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] lk_pc;
  logic            lk_hit;
  logic            lk_taken;
  logic [XLEN-1:0] lk_target;
  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic            upd_taken;
  logic [XLEN-1:0] upd_target;
  logic            upd_mispredict;

  modport master (
    output lk_pc,
    input  lk_hit, lk_taken, lk_target,
    output upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict
  );

  modport slave (
    input  lk_pc,
    output lk_hit, lk_taken, lk_target,
    input  upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict
  );
endinterface

// File: rtl/branch_predictor_sat_ctr.sv
// Saturating up/down counter next-state logic used to train a direction counter.
module bp_sat_ctr #(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] ctr_cur,
  input  logic             inc,
  input  logic             dec,
  output logic [CTR_W-1:0] ctr_next
);
  localparam logic [CTR_W-1:0] CTR_MAX = '1;

  // Step toward the requested direction, holding at either rail.
  always_comb begin
    ctr_next = ctr_cur;
    if (inc && (ctr_cur != CTR_MAX)) begin
      ctr_next = ctr_cur + CTR_W'(1);
    end else if (dec && (ctr_cur != '0)) begin
      ctr_next = ctr_cur - CTR_W'(1);
    end
  end
endmodule

// File: rtl/branch_predictor.sv
// Branch target buffer with saturating direction counters, looked up combinationally
// with the fetch PC and trained from the resolve stage.
// Optional statistics counters are built when BRANCH_PREDICTOR_STATS_EN is defined;
// otherwise stat_* read as zero.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  parameter int TAG_W = 8,
  parameter int CTR_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  branch_predictor_if.slave    bp,
  input  logic                 flush_all,
  output logic                 busy,
  output logic [31:0]          stat_updates,
  output logic [31:0]          stat_mispredicts,
  output bp_state_e            dbg_state
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] PTR_LAST  = IDX_W'(DEPTH - 1);
  localparam logic [CTR_W-1:0] CTR_ALLOC = {1'b1, {(CTR_W-1){1'b0}}};

  // Table storage
  logic             valid_q  [DEPTH];
  logic [TAG_W-1:0] tag_q    [DEPTH];
  logic [XLEN-1:0]  target_q [DEPTH];
  logic [CTR_W-1:0] ctr_q    [DEPTH];

  bp_state_e        state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             clr_en;
  logic             upd_en;

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             lk_match, upd_hit;
  logic [CTR_W-1:0] ctr_next;

  // Address bits outside index/tag (and the byte offset) are intentionally ignored.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bp.lk_pc, bp.upd_pc, bp.upd_mispredict};

  assign lk_idx  = bp.lk_pc[IDX_W+1:2];
  assign lk_tag  = bp.lk_pc[IDX_W+2 +: TAG_W];
  assign upd_idx = bp.upd_pc[IDX_W+1:2];
  assign upd_tag = bp.upd_pc[IDX_W+2 +: TAG_W];

  // Lookup: zero-latency read of the entry selected by the fetch PC; blanked while sweeping.
  always_comb begin
    lk_match     = (state_q == S_RUN) && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    bp.lk_hit    = lk_match;
    bp.lk_taken  = lk_match && ctr_q[lk_idx][CTR_W-1];
    bp.lk_target = lk_match ? target_q[lk_idx] : '0;
  end

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  bp_sat_ctr #(.CTR_W(CTR_W)) u_sat_ctr (
    .ctr_cur  (ctr_q[upd_idx]),
    .inc      (bp.upd_taken),
    .dec      (!bp.upd_taken),
    .ctr_next (ctr_next)
  );

  // Controller next-state: sweep pointer walk, flush restart, update acceptance.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    clr_en  = 1'b0;
    upd_en  = 1'b0;
    case (state_q)
      S_CLEAR: begin
        clr_en = 1'b1;
        if (flush_all) begin
          ptr_d = '0;
        end else begin
          ptr_d = ptr_q + IDX_W'(1);
          if (ptr_q == PTR_LAST) state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (flush_all) begin
          state_d = S_CLEAR;
          ptr_d   = '0;
        end else begin
          upd_en = bp.upd_valid;
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // Controller state register; reset restarts the sweep from entry 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Table write: sweep invalidation, or training from an accepted update.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (clr_en) begin
        valid_q[ptr_q] <= 1'b0;
      end else if (upd_en) begin
        if (upd_hit) begin
          ctr_q[upd_idx] <= ctr_next;
          if (bp.upd_taken) target_q[upd_idx] <= bp.upd_target;
        end else if (bp.upd_taken) begin
          valid_q[upd_idx]  <= 1'b1;
          tag_q[upd_idx]    <= upd_tag;
          target_q[upd_idx] <= bp.upd_target;
          ctr_q[upd_idx]    <= CTR_ALLOC;
        end
      end
    end
  end

  assign busy      = (state_q == S_CLEAR);
  assign dbg_state = state_q;

`ifdef BRANCH_PREDICTOR_STATS_EN
  logic [31:0] upd_cnt_q, mis_cnt_q;

  // Saturating counts of accepted updates; only reset clears them, flush does not.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      upd_cnt_q <= '0;
      mis_cnt_q <= '0;
    end else if (upd_en) begin
      if (upd_cnt_q != 32'hFFFF_FFFF) upd_cnt_q <= upd_cnt_q + 32'd1;
      if (bp.upd_mispredict && (mis_cnt_q != 32'hFFFF_FFFF)) mis_cnt_q <= mis_cnt_q + 32'd1;
    end
  end

  assign stat_updates     = upd_cnt_q;
  assign stat_mispredicts = mis_cnt_q;
`else
  assign stat_updates     = '0;
  assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed testbench for branch_predictor (DEPTH=16, TAG_W=8, CTR_W=2).
module tb_branch_predictor;
  import bp_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        flush_all;
  logic        busy;
  logic [31:0] stat_updates;
  logic [31:0] stat_mispredicts;
  bp_state_e   dbg_state;

  int checks;
  int errors;
  int exp_upd;
  int exp_mp;
  logic [31:0] exp_q[$];

  branch_predictor_if #(.XLEN(32)) bp ();

  branch_predictor #(
    .XLEN(32), .DEPTH(16), .TAG_W(8), .CTR_W(2)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bp               (bp),
    .flush_all        (flush_all),
    .busy             (busy),
    .stat_updates     (stat_updates),
    .stat_mispredicts (stat_mispredicts),
    .dbg_state        (dbg_state)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic drive_idle();
    bp.lk_pc          = '0;
    bp.upd_valid      = 1'b0;
    bp.upd_pc         = '0;
    bp.upd_taken      = 1'b0;
    bp.upd_target     = '0;
    bp.upd_mispredict = 1'b0;
    flush_all         = 1'b0;
  endtask

  // Presents one update for one clock; called at a negedge, returns at the next negedge.
  task automatic do_update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                           input logic mp, input logic accepted);
    bp.upd_valid      = 1'b1;
    bp.upd_pc         = pc;
    bp.upd_taken      = taken;
    bp.upd_target     = tgt;
    bp.upd_mispredict = mp;
    @(negedge clk);
    bp.upd_valid      = 1'b0;
    bp.upd_mispredict = 1'b0;
    if (accepted) begin
      exp_upd++;
      if (mp) exp_mp++;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    drive_idle();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    exp_upd = 0;
    exp_mp  = 0;
  endtask

  // Releases reset and counts busy cycles while probing that lookups miss.
  task automatic test_reset();
    int  cycles;
    bit  hit_seen;
    apply_reset();
    bp.lk_pc = 32'h40;
    #1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", busy); end
    checks++;
    if (dbg_state !== S_CLEAR) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, S_CLEAR); end
    checks++;
    if ({bp.lk_hit, bp.lk_taken} !== 2'b00) begin
      errors++; $display("FAIL reset_lookup: got hit=%b taken=%b expected 0 0", bp.lk_hit, bp.lk_taken);
    end
    checks++;
    if (bp.lk_target !== 32'h0) begin errors++; $display("FAIL reset_target: got %h expected 0", bp.lk_target); end
    checks++;
    if ({stat_updates, stat_mispredicts} !== 64'h0) begin
      errors++; $display("FAIL reset_stats: got %0d %0d expected 0 0", stat_updates, stat_mispredicts);
    end
    rst_n    = 1'b1;
    cycles   = 0;
    hit_seen = 1'b0;
    while (busy === 1'b1 && cycles < 100) begin
      bp.lk_pc = 32'(cycles * 4);
      #1;
      if (bp.lk_hit !== 1'b0) hit_seen = 1'b1;
      cycles++;
      @(negedge clk);
    end
    checks++;
    if (cycles != 16) begin errors++; $display("FAIL reset_busy_len: got %0d expected 16", cycles); end
    checks++;
    if (hit_seen) begin errors++; $display("FAIL reset_sweep_hit: got 1 expected 0"); end
    checks++;
    if (dbg_state !== S_RUN) begin errors++; $display("FAIL reset_run_state: got %0d expected %0d", dbg_state, S_RUN); end
    bp.lk_pc = 32'h40;
    #1;
    checks++;
    if (bp.lk_hit !== 1'b0) begin errors++; $display("FAIL reset_empty_lookup: got %b expected 0", bp.lk_hit); end
  endtask

  task automatic test_allocate();
    @(negedge clk);
    do_update(32'h40, 1'b1, 32'h100, 1'b0, 1'b1);
    bp.lk_pc = 32'h40;
    #1;
    checks++;
    if ({bp.lk_hit, bp.lk_taken} !== 2'b11) begin
      errors++; $display("FAIL alloc_hit: got hit=%b taken=%b expected 1 1", bp.lk_hit, bp.lk_taken);
    end
    checks++;
    if (bp.lk_target !== 32'h100) begin errors++; $display("FAIL alloc_target: got %h expected 100", bp.lk_target); end
    bp.lk_pc = 32'h440;
    #1;
    checks++;
    if (bp.lk_hit !== 1'b0) begin errors++; $display("FAIL alloc_other_tag: got %b expected 0", bp.lk_hit); end
    checks++;
    if (bp.lk_target !== 32'h0) begin errors++; $display("FAIL alloc_miss_target: got %h expected 0", bp.lk_target); end
  endtask

  // NT,NT,NT then T x4 then NT on 0x40: counter 2->1->0->0->1->2->3->3->2.
  task automatic test_saturation();
    logic [7:0]  tk_seq;
    logic [31:0] tgt;
    logic [31:0] exp_tk;
    tk_seq = 8'b0111_1000;
    exp_q.delete();
    exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    exp_q.push_back(32'd1); exp_q.push_back(32'd1); exp_q.push_back(32'd1); exp_q.push_back(32'd1);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      tgt = tk_seq[i] ? 32'h120 : 32'hDEAD_0000;
      do_update(32'h40, tk_seq[i], tgt, (i == 0), 1'b1);
      bp.lk_pc = 32'h40;
      #1;
      exp_tk = exp_q.pop_front();
      checks++;
      if ({bp.lk_hit, bp.lk_taken} !== {1'b1, exp_tk[0]}) begin
        errors++; $display("FAIL sat_step%0d: got hit=%b taken=%b expected 1 %b", i, bp.lk_hit, bp.lk_taken, exp_tk[0]);
      end
      if (i == 2) begin
        checks++;
        if (bp.lk_target !== 32'h100) begin errors++; $display("FAIL sat_nt_target: got %h expected 100", bp.lk_target); end
      end
      @(negedge clk);
    end
    checks++;
    if (bp.lk_target !== 32'h120) begin errors++; $display("FAIL sat_t_target: got %h expected 120", bp.lk_target); end
  endtask

  // 0x80 shares index 0 with 0x40; the same-cycle lookup must see the old entry.
  task automatic test_collision();
    bp.upd_valid      = 1'b1;
    bp.upd_pc         = 32'h80;
    bp.upd_taken      = 1'b1;
    bp.upd_target     = 32'h200;
    bp.upd_mispredict = 1'b1;
    bp.lk_pc          = 32'h80;
    #1;
    checks++;
    if (bp.lk_hit !== 1'b0) begin errors++; $display("FAIL coll_same_cycle: got %b expected 0", bp.lk_hit); end
    @(negedge clk);
    bp.upd_valid      = 1'b0;
    bp.upd_mispredict = 1'b0;
    exp_upd++;
    exp_mp++;
    #1;
    checks++;
    if ({bp.lk_hit, bp.lk_taken, bp.lk_target} !== {2'b11, 32'h200}) begin
      errors++; $display("FAIL coll_next_cycle: got hit=%b taken=%b target=%h expected 1 1 200",
                         bp.lk_hit, bp.lk_taken, bp.lk_target);
    end
    bp.lk_pc = 32'h40;
    #1;
    checks++;
    if (bp.lk_hit !== 1'b0) begin errors++; $display("FAIL coll_evicted: got %b expected 0", bp.lk_hit); end
  endtask

  task automatic test_flush();
    int          cycles;
    bit          hit_seen;
    logic [31:0] exp_su;
    logic [31:0] exp_sm;
    @(negedge clk);
    flush_all     = 1'b1;
    bp.upd_valid  = 1'b1;
    bp.upd_pc     = 32'h300;
    bp.upd_taken  = 1'b1;
    bp.upd_target = 32'h300;
    @(negedge clk);
    flush_all    = 1'b0;
    bp.upd_valid = 1'b0;
    cycles   = 0;
    hit_seen = 1'b0;
    while (busy === 1'b1 && cycles < 100) begin
      bp.upd_valid  = (cycles == 3);
      bp.upd_pc     = 32'h500;
      bp.upd_target = 32'h500;
      bp.lk_pc      = 32'h80;
      #1;
      if (bp.lk_hit !== 1'b0) hit_seen = 1'b1;
      cycles++;
      @(negedge clk);
    end
    bp.upd_valid = 1'b0;
    checks++;
    if (cycles != 16) begin errors++; $display("FAIL flush_busy_len: got %0d expected 16", cycles); end
    checks++;
    if (hit_seen) begin errors++; $display("FAIL flush_sweep_hit: got 1 expected 0"); end
    bp.lk_pc = 32'h80;
    #1;
    checks++;
    if (bp.lk_hit !== 1'b0) begin errors++; $display("FAIL flush_old_entry: got %b expected 0", bp.lk_hit); end
    bp.lk_pc = 32'h300;
    #1;
    checks++;
    if (bp.lk_hit !== 1'b0) begin errors++; $display("FAIL flush_dropped_upd: got %b expected 0", bp.lk_hit); end
    bp.lk_pc = 32'h500;
    #1;
    checks++;
    if (bp.lk_hit !== 1'b0) begin errors++; $display("FAIL flush_busy_upd: got %b expected 0", bp.lk_hit); end
`ifdef BRANCH_PREDICTOR_STATS_EN
    exp_su = 32'(exp_upd);
    exp_sm = 32'(exp_mp);
`else
    exp_su = 32'h0;
    exp_sm = 32'h0;
`endif
    checks++;
    if ({stat_updates, stat_mispredicts} !== {exp_su, exp_sm}) begin
      errors++; $display("FAIL flush_stats: got %0d %0d expected %0d %0d",
                         stat_updates, stat_mispredicts, exp_su, exp_sm);
    end
  endtask

  // Fresh reset, then five back-to-back updates, two flagged mispredict.
  task automatic test_back_to_back_stats();
    int          cycles;
    logic [31:0] exp_su;
    logic [31:0] exp_sm;
    apply_reset();
    rst_n  = 1'b1;
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
    checks++;
    if ({stat_updates, stat_mispredicts} !== 64'h0) begin
      errors++; $display("FAIL stats_after_reset: got %0d %0d expected 0 0", stat_updates, stat_mispredicts);
    end
    do_update(32'h10, 1'b1, 32'h1000, 1'b1, 1'b1);
    do_update(32'h14, 1'b1, 32'h2000, 1'b0, 1'b1);
    do_update(32'h10, 1'b0, 32'h9999, 1'b1, 1'b1);
    do_update(32'h18, 1'b0, 32'h3000, 1'b0, 1'b1);
    do_update(32'h14, 1'b1, 32'h2000, 1'b0, 1'b1);
`ifdef BRANCH_PREDICTOR_STATS_EN
    exp_su = 32'(exp_upd);
    exp_sm = 32'(exp_mp);
`else
    exp_su = 32'h0;
    exp_sm = 32'h0;
`endif
    #1;
    checks++;
    if (stat_updates !== exp_su) begin errors++; $display("FAIL stat_updates: got %0d expected %0d", stat_updates, exp_su); end
    checks++;
    if (stat_mispredicts !== exp_sm) begin errors++; $display("FAIL stat_mispredicts: got %0d expected %0d", stat_mispredicts, exp_sm); end
    bp.lk_pc = 32'h10;
    #1;
    checks++;
    if ({bp.lk_hit, bp.lk_taken, bp.lk_target} !== {2'b10, 32'h1000}) begin
      errors++; $display("FAIL b2b_0x10: got hit=%b taken=%b target=%h expected 1 0 1000", bp.lk_hit, bp.lk_taken, bp.lk_target);
    end
    bp.lk_pc = 32'h14;
    #1;
    checks++;
    if ({bp.lk_hit, bp.lk_taken, bp.lk_target} !== {2'b11, 32'h2000}) begin
      errors++; $display("FAIL b2b_0x14: got hit=%b taken=%b target=%h expected 1 1 2000", bp.lk_hit, bp.lk_taken, bp.lk_target);
    end
    bp.lk_pc = 32'h18;
    #1;
    checks++;
    if (bp.lk_hit !== 1'b0) begin errors++; $display("FAIL b2b_nt_miss: got %b expected 0", bp.lk_hit); end
  endtask

  // Test sequence and final report
  initial begin
    checks  = 0;
    errors  = 0;
    exp_upd = 0;
    exp_mp  = 0;
    rst_n   = 1'b0;
    drive_idle();
    test_reset();
    test_allocate();
    test_saturation();
    test_collision();
    test_flush();
    test_back_to_back_stats();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
